// File: rtl/ibex_ex_unit_sequencer.sv
// ibex_ex_unit_sequencer: issues operations to N functional units, owns the shared
// intermediate-value registers and holds the unit result until it is consumed.
module ibex_ex_unit_sequencer #(
  parameter int NumUnits  = 4,
  parameter int DataWidth = 32,
  parameter int ImdWidth  = 34,
  parameter int NumImd    = 2,
  parameter int MaxCycles = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 issue_valid_i,
  output logic                                 issue_ready_o,
  input  logic [$clog2(NumUnits)-1:0]          issue_unit_i,
  input  logic                                 issue_kill_i,
  output logic [NumUnits-1:0]                  unit_start_o,
  output logic [NumUnits-1:0]                  unit_sel_o,
  input  logic [NumUnits-1:0]                  unit_valid_i,
  input  logic [NumUnits*DataWidth-1:0]        unit_result_i,
  input  logic [NumUnits*NumImd-1:0]           unit_imd_we_i,
  input  logic [NumUnits*NumImd*ImdWidth-1:0]  unit_imd_d_i,
  output logic [NumImd*ImdWidth-1:0]           imd_val_q_o,
  output logic                                 result_valid_o,
  input  logic                                 result_ready_i,
  output logic [DataWidth-1:0]                 result_o,
  output logic [$clog2(NumUnits)-1:0]          result_unit_o,
  output logic                                 result_err_o,
  output logic                                 busy_o
);
  localparam int IW = $clog2(NumUnits);
  localparam int CW = $clog2(MaxCycles);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [IW:0] NU  = (IW+1)'(NumUnits);

  logic [1:0]                      state_q, state_d;
  logic [IW-1:0]                   idx_q;
  logic [CW-1:0]                   cnt_q;
  logic [NumUnits-1:0]             start_q;
  logic [NumImd-1:0][ImdWidth-1:0] imd_q;
  logic [DataWidth-1:0]            result_q;
  logic [IW-1:0]                   result_unit_q;
  logic                            err_q;
  logic                            run, hold, accept, bad_idx, sel_valid, timeout;
  logic [NumUnits-1:0]             issue_oh, idx_oh;

  assign run       = state_q == RUN;
  assign hold      = state_q == HOLD;
  assign issue_ready_o = ~issue_kill_i & ((state_q == IDLE) | (hold & result_ready_i));
  assign accept    = issue_valid_i & issue_ready_o;
  assign bad_idx   = {1'b0, issue_unit_i} >= NU;
  assign issue_oh  = NumUnits'(1) << issue_unit_i;
  assign idx_oh    = NumUnits'(1) << idx_q;
  assign sel_valid = run & unit_valid_i[idx_q];
  assign timeout   = run & ~unit_valid_i[idx_q] & (cnt_q == CW'(MaxCycles-1));

  always_comb begin
    state_d = issue_kill_i           ? IDLE :
              accept                 ? (bad_idx ? HOLD : RUN) :
              (sel_valid | timeout)  ? HOLD :
              (hold & result_ready_i) ? IDLE : state_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      start_q       <= '0;
      imd_q         <= '0;
      result_q      <= '0;
      result_unit_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= (accept & ~bad_idx) ? issue_oh : '0;
      if (accept) begin
        idx_q <= issue_unit_i;
        cnt_q <= '0;
      end else if (run) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept & ~bad_idx) begin
        imd_q <= '0;
      end else if (run & ~issue_kill_i) begin
        for (int k = 0; k < NumImd; k++)
          if (unit_imd_we_i[idx_q*NumImd+k])
            imd_q[k] <= unit_imd_d_i[(idx_q*NumImd+k)*ImdWidth +: ImdWidth];
      end
      if (!issue_kill_i) begin
        if (accept & bad_idx) begin
          result_q      <= '0;
          result_unit_q <= issue_unit_i;
          err_q         <= 1'b1;
        end else if (sel_valid) begin
          result_q      <= unit_result_i[idx_q*DataWidth +: DataWidth];
          result_unit_q <= idx_q;
          err_q         <= 1'b0;
        end else if (timeout) begin
          result_q      <= '0;
          result_unit_q <= idx_q;
          err_q         <= 1'b1;
        end
      end
    end
  end

  // A start pulse due in the first RUN cycle is dropped if that cycle is killed.
  assign unit_start_o   = issue_kill_i ? '0 : start_q;
  assign unit_sel_o     = run ? idx_oh : '0;
  assign imd_val_q_o    = imd_q;
  assign result_valid_o = hold;
  assign result_o       = result_q;
  assign result_unit_o  = result_unit_q;
  assign result_err_o   = err_q;
  assign busy_o         = state_q != IDLE;
endmodule

// File: tb/tb_ibex_ex_unit_sequencer.sv
// tb_ibex_ex_unit_sequencer: directed checks of issue, result hold, imd ownership,
// watchdog, bad index, kill and reset; a second 5-unit instance covers bad indices.
module tb_ibex_ex_unit_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         issue_valid, issue_ready, issue_kill, result_valid, result_ready, result_err, busy;
  logic [1:0]   issue_unit, result_unit;
  logic [3:0]   unit_start, unit_sel, unit_valid;
  logic [127:0] unit_result;
  logic [7:0]   imd_we;
  logic [271:0] imd_d;
  logic [67:0]  imd_q;
  logic [31:0]  result;

  logic         b_issue_valid, b_issue_ready, b_issue_kill, b_result_valid, b_result_ready, b_result_err, b_busy;
  logic [2:0]   b_issue_unit, b_result_unit;
  logic [4:0]   b_unit_start, b_unit_sel, b_unit_valid;
  logic [159:0] b_unit_result;
  logic [9:0]   b_imd_we;
  logic [339:0] b_imd_d;
  logic [67:0]  b_imd_q;
  logic [31:0]  b_result;

  int tests = 0;
  int fails = 0;

  ibex_ex_unit_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_unit_i(issue_unit), .issue_kill_i(issue_kill), .unit_start_o(unit_start),
    .unit_sel_o(unit_sel), .unit_valid_i(unit_valid), .unit_result_i(unit_result),
    .unit_imd_we_i(imd_we), .unit_imd_d_i(imd_d), .imd_val_q_o(imd_q),
    .result_valid_o(result_valid), .result_ready_i(result_ready), .result_o(result),
    .result_unit_o(result_unit), .result_err_o(result_err), .busy_o(busy)
  );

  ibex_ex_unit_sequencer #(.NumUnits(5), .MaxCycles(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(b_issue_valid), .issue_ready_o(b_issue_ready),
    .issue_unit_i(b_issue_unit), .issue_kill_i(b_issue_kill), .unit_start_o(b_unit_start),
    .unit_sel_o(b_unit_sel), .unit_valid_i(b_unit_valid), .unit_result_i(b_unit_result),
    .unit_imd_we_i(b_imd_we), .unit_imd_d_i(b_imd_d), .imd_val_q_o(b_imd_q),
    .result_valid_o(b_result_valid), .result_ready_i(b_result_ready), .result_o(b_result),
    .result_unit_o(b_result_unit), .result_err_o(b_result_err), .busy_o(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 0; issue_unit = 0; issue_kill = 0; unit_valid = 0; unit_result = '0;
    imd_we = 0; imd_d = '0; result_ready = 0;
    b_issue_valid = 0; b_issue_unit = 0; b_issue_kill = 0; b_unit_valid = 0; b_unit_result = '0;
    b_imd_we = 0; b_imd_d = '0; b_result_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2;
    tests++; if ({unit_start, unit_sel, result_valid, result, result_unit, result_err, busy} !== '0) begin
      fails++; $display("FAIL reset_outputs: got start=%b sel=%b rv=%b res=%h unit=%0d err=%b busy=%b, want all 0",
                        unit_start, unit_sel, result_valid, result, result_unit, result_err, busy); end
    step(); step();
    @(negedge clk) rst_n = 1;
    #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
    tests++; if (imd_q !== '0) begin fails++; $display("FAIL reset_imd: got %h want 0", imd_q); end
    step();
  endtask

  task automatic test_basic_and_back_to_back();
    issue_valid = 1; issue_unit = 1; #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_idle: got %b want 1", issue_ready); end
    step();
    issue_valid = 0; #1;
    tests++; if (unit_start !== 4'b0010) begin fails++; $display("FAIL basic_start_c1: got %b want 0010", unit_start); end
    tests++; if (unit_sel !== 4'b0010) begin fails++; $display("FAIL basic_sel_c1: got %b want 0010", unit_sel); end
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_run: got %b want 0", issue_ready); end
    step();
    imd_we[3] = 1; imd_d[3*34 +: 34] = 34'h2_AAAA_5555; #1;
    tests++; if (unit_start !== 4'b0000) begin fails++; $display("FAIL basic_start_c2: got %b want 0000", unit_start); end
    tests++; if (unit_sel !== 4'b0010 || result_valid !== 1'b0) begin fails++;
      $display("FAIL basic_c2: got sel=%b rv=%b want sel=0010 rv=0", unit_sel, result_valid); end
    step();
    imd_we = 0; unit_valid[1] = 1; unit_result[32 +: 32] = 32'hDEAD_BEEF; #1;
    tests++; if (unit_sel !== 4'b0010) begin fails++; $display("FAIL basic_sel_c3: got %b want 0010", unit_sel); end
    tests++; if (imd_q[34 +: 34] !== 34'h2_AAAA_5555) begin fails++; $display("FAIL basic_imd1: got %h want 2aaaa5555", imd_q[34 +: 34]); end
    step();
    unit_valid = 0; unit_result = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (result_valid !== 1'b1 || result !== 32'hDEAD_BEEF || result_unit !== 2'd1 || result_err !== 1'b0 || issue_ready !== 1'b0) begin
        fails++; $display("FAIL hold_stable_%0d: got rv=%b res=%h unit=%0d err=%b rdy=%b want 1 deadbeef 1 0 0",
                          i, result_valid, result, result_unit, result_err, issue_ready); end
      if (i < 3) step();
    end
    result_ready = 1; issue_valid = 1; issue_unit = 3; #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", issue_ready); end
    step();
    result_ready = 0; issue_valid = 0; #1;
    tests++; if (unit_start !== 4'b1000 || result_valid !== 1'b0 || busy !== 1'b1 || unit_sel !== 4'b1000) begin
      fails++; $display("FAIL b2b_run: got start=%b rv=%b busy=%b sel=%b want 1000 0 1 1000", unit_start, result_valid, busy, unit_sel); end
    unit_valid[3] = 1; unit_result[96 +: 32] = 32'h1234_5678;
    step();
    unit_valid = 0; unit_result = '0; #1;
    tests++; if (result !== 32'h1234_5678 || result_unit !== 2'd3 || result_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_result: got res=%h unit=%0d rv=%b want 12345678 3 1", result, result_unit, result_valid); end
    result_ready = 1; step(); result_ready = 0; #1;
    tests++; if (busy !== 1'b0 || result_valid !== 1'b0) begin fails++; $display("FAIL consume_idle: got busy=%b rv=%b want 0 0", busy, result_valid); end
  endtask

  task automatic test_imd_ownership();
    issue_valid = 1; issue_unit = 0; step();
    issue_valid = 0; #1;
    tests++; if (imd_q !== '0) begin fails++; $display("FAIL imd_clear_on_issue: got %h want 0", imd_q); end
    imd_we[0] = 1; imd_d[0 +: 34] = 34'h1_2345_6789;
    imd_we[4] = 1; imd_we[5] = 1; imd_d[4*34 +: 34] = '1; imd_d[5*34 +: 34] = '1;
    unit_valid[2] = 1; unit_result[64 +: 32] = 32'hBAD0_0BAD;
    step();
    imd_we = 0; imd_d = '0; unit_valid = 0; unit_result = '0; #1;
    tests++; if (imd_q !== {34'h0, 34'h1_2345_6789}) begin fails++; $display("FAIL imd_only_selected: got %h want 0_123456789", imd_q); end
    tests++; if (result_valid !== 1'b0 || busy !== 1'b1 || unit_sel !== 4'b0001) begin
      fails++; $display("FAIL imd_foreign_valid: got rv=%b busy=%b sel=%b want 0 1 0001", result_valid, busy, unit_sel); end
    unit_valid[0] = 1; unit_result[0 +: 32] = 32'hCAFE_0000; step();
    unit_valid = 0; unit_result = '0; #1;
    tests++; if (result !== 32'hCAFE_0000 || result_unit !== 2'd0 || imd_q[0 +: 34] !== 34'h1_2345_6789) begin
      fails++; $display("FAIL imd_hold: got res=%h unit=%0d imd0=%h want cafe0000 0 123456789", result, result_unit, imd_q[0 +: 34]); end
    result_ready = 1; step(); result_ready = 0;
  endtask

  task automatic test_timeout();
    int n;
    issue_valid = 1; issue_unit = 2; step();
    issue_valid = 0; #1;
    n = 0;
    while (!result_valid && n < 100) begin n++; step(); #1; end
    tests++; if (n != 64) begin fails++; $display("FAIL timeout_cycles: got %0d want 64", n); end
    tests++; if (result_err !== 1'b1 || result !== 32'h0) begin fails++; $display("FAIL timeout_result: got err=%b res=%h want 1 0", result_err, result); end
    result_ready = 1; step(); result_ready = 0;
    b_issue_valid = 1; b_issue_unit = 4; step();
    b_issue_valid = 0; #1;
    n = 0;
    while (!b_result_valid && n < 20) begin n++; step(); #1; end
    tests++; if (n != 4 || b_result_err !== 1'b1) begin fails++; $display("FAIL timeout4: got cycles=%0d err=%b want 4 1", n, b_result_err); end
    b_result_ready = 1; step(); b_result_ready = 0;
  endtask

  task automatic test_bad_index();
    b_issue_valid = 1; b_issue_unit = 5; #1;
    tests++; if (b_issue_ready !== 1'b1) begin fails++; $display("FAIL bad_idx_ready: got %b want 1", b_issue_ready); end
    step();
    b_issue_valid = 0; #1;
    tests++; if (b_result_valid !== 1'b1 || b_result_err !== 1'b1 || b_result !== 32'h0 || b_unit_start !== 5'b0) begin
      fails++; $display("FAIL bad_idx_hold: got rv=%b err=%b res=%h start=%b want 1 1 0 00000",
                        b_result_valid, b_result_err, b_result, b_unit_start); end
    b_result_ready = 1; step(); b_result_ready = 0; #1;
    tests++; if (b_busy !== 1'b0) begin fails++; $display("FAIL bad_idx_consume: got busy=%b want 0", b_busy); end
  endtask

  task automatic test_kill();
    issue_valid = 1; issue_unit = 1; step();
    issue_valid = 0; unit_valid[1] = 1; unit_result[32 +: 32] = 32'h5555_5555; issue_kill = 1; #1;
    tests++; if (issue_ready !== 1'b0 || unit_start !== 4'b0) begin
      fails++; $display("FAIL kill_first_run: got rdy=%b start=%b want 0 0000", issue_ready, unit_start); end
    step();
    unit_valid = 0; unit_result = '0; issue_kill = 0; #1;
    tests++; if (busy !== 1'b0 || result_valid !== 1'b0) begin fails++; $display("FAIL kill_vs_valid: got busy=%b rv=%b want 0 0", busy, result_valid); end
    issue_valid = 1; issue_unit = 2; issue_kill = 1; #1;
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL kill_issue_ready: got %b want 0", issue_ready); end
    step();
    issue_valid = 0; issue_kill = 0; #1;
    tests++; if (busy !== 1'b0 || unit_start !== 4'b0 || unit_sel !== 4'b0) begin
      fails++; $display("FAIL kill_vs_issue: got busy=%b start=%b sel=%b want 0 0000 0000", busy, unit_start, unit_sel); end
    issue_valid = 1; issue_unit = 1; step();
    issue_valid = 0; unit_valid[1] = 1; step();
    unit_valid = 0; issue_kill = 1; #1;
    tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL kill_pre_hold: got rv=%b want 1", result_valid); end
    step();
    issue_kill = 0; #1;
    tests++; if (result_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL kill_in_hold: got rv=%b busy=%b want 0 0", result_valid, busy); end
  endtask

  task automatic test_reset_mid_run();
    issue_valid = 1; issue_unit = 2; step();
    issue_valid = 0; imd_we[4] = 1; imd_d[4*34 +: 34] = 34'h3_0000_0001; step();
    imd_we = 0; imd_d = '0; #1;
    tests++; if (imd_q[0 +: 34] !== 34'h3_0000_0001) begin fails++; $display("FAIL pre_reset_imd: got %h want 300000001", imd_q[0 +: 34]); end
    for (int i = 0; i < 4; i++) step();
    rst_n = 0; #1;
    tests++; if ({unit_start, unit_sel, result_valid, result_err, busy} !== '0 || imd_q !== '0) begin
      fails++; $display("FAIL reset_mid_run: got start=%b sel=%b rv=%b err=%b busy=%b imd=%h want all 0",
                        unit_start, unit_sel, result_valid, result_err, busy, imd_q); end
    step();
    @(negedge clk) rst_n = 1;
    #1;
    tests++; if (issue_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reset_release: got rdy=%b busy=%b want 1 0", issue_ready, busy); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_and_back_to_back();
    test_imd_ownership();
    test_timeout();
    test_bad_index();
    test_kill();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
